// File: rtl/encrypt_pkg.sv
// Shared types and constants for the encrypt engine: FSM states, default widths,
// mode encodings and the counter-width helper.
package encrypt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_W        = 128;
    localparam int DEFAULT_CLOCK_PER_BIT = 10417;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Width needed to hold 0..terminal; never narrower than one bit.
    function automatic int cnt_width(input int terminal);
        return (terminal > 0) ? $clog2(terminal + 1) : 1;
    endfunction

endpackage

// File: rtl/round_unit.sv
// One combinational cipher round. Encrypt: rotl1(block ^ key) + key.
// Decrypt is the exact inverse: rotr1(block - key) ^ key.
module round_unit
    import encrypt_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] block_i,
    input  logic [DATA_W-1:0] key_i,
    input  logic              mode_i,
    output logic [DATA_W-1:0] block_o
);

    logic [DATA_W-1:0] mixed;
    logic [DATA_W-1:0] rotated;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] unrotated;

    always_comb begin
        mixed     = block_i ^ key_i;
        rotated   = {mixed[DATA_W-2:0], mixed[DATA_W-1]};
        diff      = block_i - key_i;
        unrotated = {diff[0], diff[DATA_W-1:1]};
        block_o   = (mode_i == MODE_DEC) ? (unrotated ^ key_i) : (rotated + key_i);
    end

endmodule

// File: rtl/encrypt_engine.sv
// Iterative block cipher: one round per clock, then a UART-paced delay before the
// result is published and held valid for a fixed number of bit-times.
module encrypt_engine
    import encrypt_pkg::*;
#(
    parameter int DATA_W        = DEFAULT_DATA_W,
    parameter int NUM_KEYS      = 2,
    parameter int CLOCK_PER_BIT = DEFAULT_CLOCK_PER_BIT,
    parameter int DELAY_BITS    = 159,
    parameter int HOLD_BITS     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          data,
    input  logic [NUM_KEYS*DATA_W-1:0] keys,
    input  logic                       mode,
    input  logic                       data_state,
    output logic [DATA_W-1:0]          encoded_data,
    output logic                       encoded_state,
    output logic                       busy
);

    localparam int DLY_TERM  = DELAY_BITS * CLOCK_PER_BIT;
    localparam int HOLD_TERM = HOLD_BITS * CLOCK_PER_BIT;
    localparam int DLY_W     = cnt_width(DLY_TERM);
    localparam int HOLD_W    = cnt_width(HOLD_TERM);
    localparam int RIDX_W    = cnt_width(NUM_KEYS - 1);

    localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(NUM_KEYS - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST   = DLY_W'(DLY_TERM);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_TERM);

    state_t                     state_q;
    logic [RIDX_W-1:0]          round_idx_q;
    logic [DLY_W-1:0]           dly_cnt_q;
    logic [HOLD_W-1:0]          hold_cnt_q;
    logic [DATA_W-1:0]          work_q;
    logic                       mode_q;
    logic [NUM_KEYS*DATA_W-1:0] keys_q;

    logic [DATA_W-1:0] work_d;
    logic [DATA_W-1:0] key_cur;
    logic [RIDX_W-1:0] key_idx;
    logic [DATA_W-1:0] key_arr [NUM_KEYS];

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        assign key_arr[gi] = keys_q[gi*DATA_W +: DATA_W];
    end

    // Decrypt walks the key schedule backwards.
    assign key_idx = (mode_q == MODE_DEC) ? (LAST_ROUND - round_idx_q) : round_idx_q;

    always_comb begin
        key_cur = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (key_idx == RIDX_W'(k)) begin
                key_cur = key_arr[k];
            end
        end
    end

    round_unit #(
        .DATA_W (DATA_W)
    ) u_round (
        .block_i (work_q),
        .key_i   (key_cur),
        .mode_i  (mode_q),
        .block_o (work_d)
    );

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            round_idx_q   <= '0;
            dly_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            work_q        <= '0;
            mode_q        <= MODE_ENC;
            keys_q        <= '0;
            encoded_data  <= '0;
            encoded_state <= 1'b0;
        end else begin
            // Hold counter starts at 1 on publish, so the level lasts HOLD_TERM cycles.
            if (encoded_state) begin
                if (hold_cnt_q == HOLD_LAST) begin
                    encoded_state <= 1'b0;
                end else begin
                    hold_cnt_q <= hold_cnt_q + 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (data_state) begin
                        work_q        <= data;
                        mode_q        <= mode;
                        keys_q        <= keys;
                        round_idx_q   <= '0;
                        hold_cnt_q    <= '0;
                        encoded_state <= 1'b0;
                        state_q       <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    work_q <= work_d;
                    if (round_idx_q == LAST_ROUND) begin
                        dly_cnt_q <= '0;
                        state_q   <= ST_WAIT;
                    end else begin
                        round_idx_q <= round_idx_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (dly_cnt_q == DLY_LAST) begin
                        encoded_data  <= work_q;
                        encoded_state <= 1'b1;
                        hold_cnt_q    <= HOLD_W'(1);
                        state_q       <= ST_IDLE;
                    end else begin
                        dly_cnt_q <= dly_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/encrypt_engine.md
ENCRYPT_ENGINE -- requirements
Module: encrypt_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 128, block and per-round key width in bits.
REQ-002 SHALL have parameter NUM_KEYS, default 2, number of rounds (one key each); legal range 1..16.
REQ-003 SHALL have parameter CLOCK_PER_BIT, default 10417, clocks per UART bit (100 MHz / 9600 baud).
REQ-004 SHALL have parameter DELAY_BITS, default 159, bit-times from end of last round to result publish; 0 legal.
REQ-005 SHALL have parameter HOLD_BITS, default 16, bit-times encoded_state stays high; minimum 1.
REQ-006 SHALL have port clk input 1, single clock, all logic on posedge.
REQ-007 SHALL have port rst input 1, synchronous active-high reset.
REQ-008 SHALL have port data input DATA_W, plaintext/ciphertext block.
REQ-009 SHALL have port keys input NUM_KEYS*DATA_W, key k at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port mode input 1, 0 = encrypt, 1 = decrypt.
REQ-011 SHALL have port data_state input 1, start strobe, sampled high in IDLE only.
REQ-012 SHALL have port encoded_data output DATA_W, registered result.
REQ-013 SHALL have port encoded_state output 1, result-valid level.
REQ-014 SHALL have port busy output 1, high in ROUND or WAIT.

Function
REQ-015 SHALL implement FSM states IDLE, ROUND, WAIT; IDLE on reset.
REQ-016 In IDLE with data_state=1, SHALL latch data, mode and keys into internal registers, clear round index, enter ROUND next cycle.
REQ-017 In ROUND, SHALL apply one round per cycle to the working register; encrypt uses key k at round k, decrypt uses key NUM_KEYS-1-k with inverse round.
REQ-018 After round NUM_KEYS-1, SHALL enter WAIT with delay counter cleared; round-index wrap SHALL NOT occur.
REQ-019 In WAIT, SHALL count DELAY_BITS*CLOCK_PER_BIT cycles, then load encoded_data from working register, set encoded_state, start hold counter, return to IDLE.
REQ-020 Latency SHALL be exactly NUM_KEYS + DELAY_BITS*CLOCK_PER_BIT + 1 cycles from the start-sampling edge to the edge where encoded_state rises.
REQ-021 encoded_state SHALL fall after HOLD_BITS*CLOCK_PER_BIT cycles high, unless cleared earlier per REQ-022.
REQ-022 A start accepted while encoded_state is high SHALL clear encoded_state on the same edge; encoded_data SHALL hold its previous value until the new result publishes.
REQ-023 data_state while busy SHALL be ignored, with no queuing; changes on data, keys or mode while busy SHALL NOT affect the result.
REQ-024 encoded_data SHALL change only on a publish edge.
REQ-025 Counters SHALL be sized with $clog2 of their terminal count plus 1 and SHALL saturate, not wrap.

Reset
REQ-026 rst=1 SHALL force on the next edge: state IDLE, encoded_data 0, encoded_state 0, busy 0, all counters and working register 0.
REQ-027 Reset mid-ROUND or mid-WAIT SHALL abort the operation with no publish; data_state in the same cycle as rst SHALL be ignored.

Structure
REQ-028 Shared package encrypt_pkg SHALL hold the state enum, default DATA_W/CLOCK_PER_BIT, and MODE_ENC/MODE_DEC constants.
REQ-029 The combinational round SHALL be one sub-module round_unit (inputs: block, key, mode; output: block), instantiated once and iterated.

Verification (bench overrides: CLOCK_PER_BIT=2, DELAY_BITS=2, HOLD_BITS=3, NUM_KEYS=2)
REQ-030 Encrypt data=0x00112233445566778899aabbccddeeff, keys from model -> encoded_state rises exactly 7 cycles after start, value equals the round_unit behavioural model, high 6 cycles.
REQ-031 Decrypt of REQ-030 output with the same keys -> encoded_data=0x00112233445566778899aabbccddeeff.
REQ-032 data_state pulsed at cycles 1..6 of a busy operation, with data changed -> single publish, value of the original block.
REQ-033 New start 2 cycles after publish -> encoded_state low next edge, encoded_data unchanged until second publish.
REQ-034 rst asserted in WAIT -> no publish, all outputs 0; next start completes normally.
REQ-035 NUM_KEYS=1, DELAY_BITS=0 -> encoded_state rises 2 cycles after start.
